// File: rtl/ins_enc_pkg.sv
// Shared constants for the instruction encoder/loader: format codes, FSM state
// encoding, error codes and the 16-bit word field positions used by the decoder.
package ins_enc_pkg;

  localparam logic [1:0] FMT_REG      = 2'd0;
  localparam logic [1:0] FMT_IMM8     = 2'd1;
  localparam logic [1:0] FMT_IMM5     = 2'd2;
  localparam logic [1:0] FMT_RAW_CODE = 2'd3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_RDREQ = 3'd3;
  localparam logic [2:0] S_RDCHK = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_FAULT = 3'd6;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_IMM5     = 2'd1;
  localparam logic [1:0] ERR_ADDR     = 2'd2;
  localparam logic [1:0] ERR_READBACK = 2'd3;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 13;
  localparam int OP_HI  = 12;
  localparam int OP_LO  = 11;
  localparam int RN_HI  = 10;
  localparam int RN_LO  = 8;
  localparam int RD_HI  = 7;
  localparam int RD_LO  = 5;
  localparam int SH_HI  = 4;
  localparam int SH_LO  = 3;
  localparam int RM_HI  = 2;
  localparam int RM_LO  = 0;
  localparam int IMM8_HI = 7;
  localparam int IMM5_HI = 4;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [2:0]  rm;
    logic [1:0]  shift;
    logic [15:0] imm16;
  } ins_fields_t;

  // imm5 is a signed -16..15 value carried in the low byte; the upper three bits must sign-extend bit 4
  function automatic logic imm5_in_range(input logic [7:0] imm);
    return (imm[7:5] == {3{imm[4]}});
  endfunction

endpackage

// File: rtl/ins_packer.sv
// Combinational packer: turns an instruction field bundle plus format code into a
// 16-bit Simple RISC Machine word and flags imm5 values that do not fit.
module ins_packer
  import ins_enc_pkg::*;
#(
  parameter int FMT_RAW = 3
) (
  input  ins_fields_t fields,
  input  logic [1:0]  fmt,
  output logic [15:0] word,
  output logic        imm5_err
);

  localparam logic [1:0] RAW_SEL = FMT_RAW[1:0];

  always_comb begin
    word     = '0;
    imm5_err = 1'b0;
    if (fmt == RAW_SEL) begin
      word = fields.imm16;
    end else begin
      word[OPC_HI:OPC_LO] = fields.opcode;
      word[OP_HI:OP_LO]   = fields.op;
      word[RN_HI:RN_LO]   = fields.rn;
      case (fmt)
        FMT_IMM8: begin
          word[IMM8_HI:0] = fields.imm16[IMM8_HI:0];
        end
        FMT_IMM5: begin
          word[RD_HI:RD_LO] = fields.rd;
          word[IMM5_HI:0]   = fields.imm16[IMM5_HI:0];
          imm5_err          = !imm5_in_range(fields.imm16[7:0]);
        end
        default: begin
          word[RD_HI:RD_LO] = fields.rd;
          word[SH_HI:SH_LO] = fields.shift;
          word[RM_HI:RM_LO] = fields.rm;
        end
      endcase
    end
  end

endmodule

// File: rtl/ins_encoder_loader.sv
// Program loader: packs field bundles into instruction words and writes them to
// memory from a start address. Define INS_READBACK_EN to verify each write by readback.
module ins_encoder_loader
  import ins_enc_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int FMT_RAW = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [1:0]        fmt,
  input  logic [2:0]        opcode,
  input  logic [1:0]        op,
  input  logic [2:0]        rn,
  input  logic [2:0]        rd,
  input  logic [2:0]        rm,
  input  logic [1:0]        shift,
  input  logic [15:0]       imm16,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  input  logic [15:0]       mem_dout,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [2:0]  state;
  logic        last_q;
  ins_fields_t fields;
  logic [15:0] packed_word;
  logic        imm5_err;
  logic        at_top;
  logic [2:0]  after_write;

  assign fields = '{opcode: opcode, op: op, rn: rn, rd: rd, rm: rm,
                    shift: shift, imm16: imm16};

  ins_packer #(.FMT_RAW(FMT_RAW)) u_packer (
    .fields   (fields),
    .fmt      (fmt),
    .word     (packed_word),
    .imm5_err (imm5_err)
  );

  // Status outputs decode straight from state so an async reset clears them at once
  assign in_ready  = (state == S_LOAD);
  assign mem_write = (state == S_WRITE);
  assign done      = (state == S_DONE);
  assign busy      = (state == S_LOAD) || (state == S_WRITE) ||
                     (state == S_RDREQ) || (state == S_RDCHK);

  assign at_top = (mem_addr == {ADDR_W{1'b1}});

  always_comb begin
    after_write = S_LOAD;
    if (last_q)      after_write = S_DONE;
    else if (at_top) after_write = S_FAULT;
  end

`ifndef INS_READBACK_EN
  logic mem_dout_unused;
  assign mem_dout_unused = ^mem_dout;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      mem_addr <= '0;
      mem_din  <= '0;
      count    <= '0;
      error    <= 1'b0;
      err_code <= ERR_NONE;
      last_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_FAULT: begin
          if (start) begin
            mem_addr <= start_addr;
            count    <= '0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (imm5_err) begin
              error    <= 1'b1;
              err_code <= ERR_IMM5;
              state    <= S_FAULT;
            end else begin
              mem_din <= packed_word;
              last_q  <= in_last;
              count   <= count + COUNT_ONE;
              state   <= S_WRITE;
            end
          end
        end
`ifdef INS_READBACK_EN
        S_WRITE: state <= S_RDREQ;
        S_RDREQ: state <= S_RDCHK;
        S_RDCHK: begin
          if (mem_dout != mem_din) begin
            error    <= 1'b1;
            err_code <= ERR_READBACK;
            state    <= S_FAULT;
          end else begin
            state <= after_write;
            if (!last_q && at_top) begin
              error    <= 1'b1;
              err_code <= ERR_ADDR;
            end else if (!last_q) begin
              mem_addr <= mem_addr + ADDR_ONE;
            end
          end
        end
`else
        S_WRITE: begin
          state <= after_write;
          if (!last_q && at_top) begin
            error    <= 1'b1;
            err_code <= ERR_ADDR;
          end else if (!last_q) begin
            mem_addr <= mem_addr + ADDR_ONE;
          end
        end
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ins_encoder_loader.sv
// Scoreboard bench for ins_encoder_loader: expected writes are queued when a bundle
// is driven and popped when the DUT strobes mem_write.
module tb_ins_encoder_loader;

  localparam int ADDR_W = 8;
`ifdef INS_READBACK_EN
  localparam int EXP_3WORD_CYCLES = 12;
`else
  localparam int EXP_3WORD_CYCLES = 6;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_last = 1'b0;
  logic [1:0]        fmt = '0;
  logic [2:0]        opcode = '0;
  logic [1:0]        op = '0;
  logic [2:0]        rn = '0;
  logic [2:0]        rd = '0;
  logic [2:0]        rm = '0;
  logic [1:0]        shift = '0;
  logic [15:0]       imm16 = '0;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_din;
  logic [15:0]       mem_dout = '0;
  logic              busy;
  logic              done;
  logic              error;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   count;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   done_cyc = 0;
  logic corrupt = 1'b0;
  logic [15:0] mem [0:(1<<ADDR_W)-1];

  ins_encoder_loader #(.ADDR_W(ADDR_W), .FMT_RAW(3)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .fmt(fmt),
    .opcode(opcode), .op(op), .rn(rn), .rd(rd), .rm(rm), .shift(shift),
    .imm16(imm16), .mem_write(mem_write), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .count(count)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one-cycle read latency; corrupt flips bit 0 on readback
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr] ^ {15'b0, corrupt};
  end

  task automatic check_output(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && mem_write) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_write", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("wr_addr", 64'(mem_addr), 64'(mon_e.addr));
        check_output("wr_data", 64'(mem_din), 64'(mon_e.data));
      end
    end
  end

  function automatic logic [15:0] model_word(input logic [1:0] f, input logic [2:0] opc,
      input logic [1:0] o, input logic [2:0] r_n, input logic [2:0] r_d,
      input logic [2:0] r_m, input logic [1:0] sh, input logic [15:0] imm);
    case (f)
      2'd0:    return {opc, o, r_n, r_d, sh, r_m};
      2'd1:    return {opc, o, r_n, imm[7:0]};
      2'd2:    return {opc, o, r_n, r_d, imm[4:0]};
      default: return imm;
    endcase
  endfunction

  task automatic pulse_start(input logic [ADDR_W-1:0] addr);
    start_addr = addr;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after acceptance (or after the wait expires)
  task automatic apply_stimulus(input logic [1:0] f, input logic [2:0] opc,
      input logic [1:0] o, input logic [2:0] r_n, input logic [2:0] r_d,
      input logic [2:0] r_m, input logic [1:0] sh, input logic [15:0] imm,
      input logic last, input bit exp_wr, input logic [ADDR_W-1:0] exp_addr,
      input logic [15:0] exp_word, output bit accepted);
    int  waited;
    wr_t w;
    fmt = f; opcode = opc; op = o; rn = r_n; rd = r_d; rm = r_m;
    shift = sh; imm16 = imm; in_last = last; in_valid = 1'b1;
    if (exp_wr) begin
      w.addr = exp_addr;
      w.data = exp_word;
      exp_q.push_back(w);
    end
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    accepted = in_ready;
    if (accepted) begin
      accept_cyc = cyc;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (done) begin
        seen = 1'b1;
        done_cyc = cyc;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit acc;
    bit seen;
    int first_cyc;
    logic [2:0]  r_opc, r_rn, r_rd, r_rm;
    logic [1:0]  r_op, r_sh, r_fmt;
    logic [15:0] r_imm;

    repeat (2) @(negedge clk);
    check_output("rst_ctrl", {in_ready, mem_write, busy, done, error, err_code}, 64'd0);
    check_output("rst_data", {count, mem_addr, mem_din}, 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_output("idle_ready", 64'(in_ready), 64'd0);

    // REG word then IMM8 last word
    pulse_start(8'h10);
    check_output("load_ready", {in_ready, busy}, 64'h3);
    check_output("start_addr", 64'(mem_addr), 64'h10);
    check_output("start_count", 64'(count), 64'd0);
    apply_stimulus(2'd0, 3'b101, 2'b00, 3'd1, 3'd2, 3'd3, 2'b01, 16'h0000, 1'b0,
                   1'b1, 8'h10, 16'hA14B, acc);
    check_output("reg_accept", 64'(acc), 64'd1);
    check_output("reg_wstrobe", 64'(mem_write), 64'd1);
    apply_stimulus(2'd1, 3'b110, 2'b10, 3'd0, 3'd0, 3'd0, 2'b00, 16'h007F, 1'b1,
                   1'b1, 8'h11, 16'hD07F, acc);
    check_output("imm8_accept", 64'(acc), 64'd1);
    wait_done(seen);
    check_output("done_seen", 64'(seen), 64'd1);
    check_output("done_count", 64'(count), 64'd2);
    @(negedge clk);
    check_output("after_done", {done, in_ready, busy, error}, 64'd0);

    // IMM5 boundaries and range violation
    pulse_start(8'h20);
    apply_stimulus(2'd2, 3'b011, 2'b00, 3'd2, 3'd3, 3'd0, 2'b00, 16'h00F0, 1'b0,
                   1'b1, 8'h20, 16'h6270, acc);
    apply_stimulus(2'd2, 3'b011, 2'b00, 3'd2, 3'd3, 3'd0, 2'b00, 16'hAB0F, 1'b0,
                   1'b1, 8'h21, 16'h626F, acc);
    apply_stimulus(2'd2, 3'b011, 2'b00, 3'd2, 3'd3, 3'd0, 2'b00, 16'h0010, 1'b0,
                   1'b0, 8'h00, 16'h0000, acc);
    check_output("imm5_accept", 64'(acc), 64'd1);
    check_output("imm5_err", {error, err_code}, 64'h5);
    check_output("imm5_idle", {in_ready, busy, mem_write}, 64'd0);
    check_output("imm5_count", 64'(count), 64'd2);
    check_output("imm5_addr", 64'(mem_addr), 64'h22);

    // Address overflow at the top of memory
    pulse_start(8'hFF);
    check_output("restart_clear", {error, err_code}, 64'd0);
    apply_stimulus(2'd3, 3'd0, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h1234, 1'b0,
                   1'b1, 8'hFF, 16'h1234, acc);
    apply_stimulus(2'd3, 3'd0, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h5678, 1'b0,
                   1'b0, 8'h00, 16'h0000, acc);
    check_output("ovf_refused", 64'(acc), 64'd0);
    check_output("ovf_err", {error, err_code}, 64'h6);
    check_output("ovf_addr", 64'(mem_addr), 64'hFF);
    check_output("ovf_count", 64'(count), 64'd1);
    pulse_start(8'h40);
    check_output("ovf_clear", {error, err_code, busy}, 64'h1);
    check_output("ovf_restart_addr", 64'(mem_addr), 64'h40);

    // Async reset while a write is in flight
    apply_stimulus(2'd3, 3'd0, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'hBEEF, 1'b0,
                   1'b1, 8'h40, 16'hBEEF, acc);
    #1;
    check_output("pre_rst_write", 64'(mem_write), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    check_output("mid_rst_ctrl", {in_ready, mem_write, busy, done, error, err_code}, 64'd0);
    check_output("mid_rst_data", {count, mem_addr, mem_din}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_output("post_rst_idle", {in_ready, busy}, 64'd0);

    // Three back-to-back words: throughput
    pulse_start(8'h50);
    apply_stimulus(2'd3, 3'd0, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h1111, 1'b0,
                   1'b1, 8'h50, 16'h1111, acc);
    first_cyc = accept_cyc;
    apply_stimulus(2'd3, 3'd0, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h2222, 1'b0,
                   1'b1, 8'h51, 16'h2222, acc);
    apply_stimulus(2'd3, 3'd0, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h3333, 1'b1,
                   1'b1, 8'h52, 16'h3333, acc);
    wait_done(seen);
    check_output("tput_done", 64'(seen), 64'd1);
    check_output("tput_cycles", 64'(done_cyc - first_cyc), 64'(EXP_3WORD_CYCLES));
    check_output("tput_count", 64'(count), 64'd3);

    // Random REG/IMM8 bundles checked against the packing model
    @(negedge clk);
    pulse_start(8'h60);
    for (int i = 0; i < 4; i++) begin
      r_fmt = 2'($urandom_range(0, 1));
      r_opc = 3'($urandom); r_op = 2'($urandom); r_rn = 3'($urandom);
      r_rd = 3'($urandom); r_rm = 3'($urandom); r_sh = 2'($urandom);
      r_imm = 16'($urandom);
      apply_stimulus(r_fmt, r_opc, r_op, r_rn, r_rd, r_rm, r_sh, r_imm, (i == 3),
                     1'b1, 8'(8'h60 + i),
                     model_word(r_fmt, r_opc, r_op, r_rn, r_rd, r_rm, r_sh, r_imm), acc);
    end
    wait_done(seen);
    check_output("rand_done", 64'(seen), 64'd1);

`ifdef INS_READBACK_EN
    // Corrupted readback must fault after the check cycle
    @(negedge clk);
    corrupt = 1'b1;
    pulse_start(8'h80);
    apply_stimulus(2'd3, 3'd0, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0F0F, 1'b0,
                   1'b1, 8'h80, 16'h0F0F, acc);
    for (int i = 0; i < 10 && !error; i++) @(negedge clk);
    check_output("rdbk_err", {error, err_code}, 64'h7);
    check_output("rdbk_addr", 64'(mem_addr), 64'h80);
    corrupt = 1'b0;
`endif

    @(negedge clk);
    check_output("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
